// File: rtl/csa_acc_seq.sv
// Sequential multi-operand accumulator: one W-bit carry-save stage folds a packet of operands
// into a redundant sum/carry pair, then a single carry-propagate add resolves it.
// Optional operand counter and out_count port: define CSA_ACC_CNT_EN.
module csa_acc_seq #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
`ifdef CSA_ACC_CNT_EN
  ,
  output logic [7:0]   out_count
`endif
);

  localparam logic [1:0] ST_ACC = 2'd0;
  localparam logic [1:0] ST_RES = 2'd1;
  localparam logic [1:0] ST_OUT = 2'd2;

  function automatic logic [W-1:0] csa_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c);
    return a ^ b ^ c;
  endfunction

  function automatic logic [W-2:0] csa_maj(input logic [W-2:0] a, input logic [W-2:0] b,
                                           input logic [W-2:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [W-1:0] r_s;
  // Only the low W-1 carries are kept: the majority out of bit W-1 would shift past the result.
  logic [W-2:0] r_c;
  logic [W-1:0] r_out_data;
  logic [W-1:0] w_y;
  logic [W-1:0] w_s_nxt;
  logic [W-2:0] w_c_nxt;

  assign w_y       = {r_c, 1'b0};
  assign w_s_nxt   = csa_sum(r_s, w_y, in_data);
  assign w_c_nxt   = csa_maj(r_s[W-2:0], w_y[W-2:0], in_data[W-2:0]);
  assign in_ready  = (r_state == ST_ACC);
  assign out_valid = (r_state == ST_OUT);
  assign out_data  = r_out_data;

  // Next-state decode for the accumulate / resolve / output sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC: begin
        if (in_valid && in_last) begin
          w_state_nxt = ST_RES;
        end else begin
          w_state_nxt = ST_ACC;
        end
      end
      ST_RES: w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          w_state_nxt = ST_ACC;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // State, redundant accumulator and resolved result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_ACC;
      r_s        <= {W{1'b0}};
      r_c        <= {(W-1){1'b0}};
      r_out_data <= {W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_ACC: begin
          if (in_valid) begin
            r_s <= w_s_nxt;
            r_c <= w_c_nxt;
          end else begin
            r_s <= r_s;
            r_c <= r_c;
          end
        end
        ST_RES: r_out_data <= r_s + w_y;
        ST_OUT: begin
          if (out_ready) begin
            r_s <= {W{1'b0}};
            r_c <= {(W-1){1'b0}};
          end else begin
            r_s <= r_s;
            r_c <= r_c;
          end
        end
        default: begin
          r_s <= {W{1'b0}};
          r_c <= {(W-1){1'b0}};
        end
      endcase
    end
  end

`ifdef CSA_ACC_CNT_EN
  logic [7:0] r_cnt;
  logic [7:0] r_out_count;

  assign out_count = r_out_count;

  // Saturating operand counter, snapshotted when the result is resolved.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= 8'd0;
      r_out_count <= 8'd0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (in_valid && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        ST_RES: r_out_count <= r_cnt;
        ST_OUT: begin
          if (out_ready) begin
            r_cnt       <= 8'd0;
            r_out_count <= 8'd0;
          end else begin
            r_cnt       <= r_cnt;
            r_out_count <= r_out_count;
          end
        end
        default: begin
          r_cnt       <= 8'd0;
          r_out_count <= 8'd0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_csa_acc_seq.sv
// Self-checking bench for csa_acc_seq: directed vector table, reset corner cases and
// randomized packets checked against a plain-arithmetic packet-sum model.
module tb_csa_acc_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef CSA_ACC_CNT_EN
  logic [7:0]  out_count;
`endif

  csa_acc_seq #(.W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CSA_ACC_CNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [23:0] pkt [0:299];

  typedef struct {
    int              n;
    logic [3:0][23:0] ops;
    bit              gaps;
    int              hold;
    logic [23:0]     exp;
    int              exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends pkt[0..n-1] as one packet, then checks latency, result, hold and handshake.
  task automatic run_packet(input int n, input bit gaps, input int hold,
                            input logic [23:0] exp, input int exp_cnt, input string tag);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        for (int b = 0; b < int'($urandom_range(1, 2)); b++) begin
          in_valid = 1'b0;
          in_data  = 24'($urandom);
          in_last  = 1'($urandom);
          tick();
        end
      end
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == n - 1);
      if (i == 0 || i == n - 1) chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
      tick();
    end
    // Garbage while not ready must be ignored.
    in_valid  = 1'b1;
    in_data   = 24'hABCDEF;
    in_last   = 1'b1;
    out_ready = (hold == 0);
    chk({tag, " res_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " res_ready"}, {31'd0, in_ready}, 32'd0);
    tick();
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " out_data"}, {8'd0, out_data}, {8'd0, exp});
`ifdef CSA_ACC_CNT_EN
    chk({tag, " out_count"}, {24'd0, out_count}, exp_cnt);
`endif
    for (int h = 0; h < hold; h++) begin
      chk({tag, " hold_ready"}, {31'd0, in_ready}, 32'd0);
      tick();
      chk({tag, " hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, " hold_data"}, {8'd0, out_data}, {8'd0, exp});
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    chk({tag, " hs_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " hs_ready"}, {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 24'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_data", {8'd0, out_data}, 32'd0);
`ifdef CSA_ACC_CNT_EN
    chk("rst out_count", {24'd0, out_count}, 32'd0);
`endif
  endtask

  vec_t vecs [0:4];

  initial begin
    vecs[0] = '{n:3, ops:{24'd0, 24'd9, 24'd7, 24'd5}, gaps:1'b0, hold:0, exp:24'd21, exp_cnt:3};
    vecs[1] = '{n:3, ops:{24'd0, 24'd3, 24'hFFFFFE, 24'hFFFFFF}, gaps:1'b0, hold:0,
                exp:24'h000000, exp_cnt:3};
    vecs[2] = '{n:2, ops:{24'd0, 24'd0, 24'h800000, 24'h800000}, gaps:1'b0, hold:1,
                exp:24'h000000, exp_cnt:2};
    vecs[3] = '{n:1, ops:{24'd0, 24'd0, 24'd0, 24'h123456}, gaps:1'b0, hold:0,
                exp:24'h123456, exp_cnt:1};
    vecs[4] = '{n:4, ops:{24'h0F0F0F, 24'h3FFFFF, 24'h000101, 24'h7A5A5A}, gaps:1'b1, hold:5,
                exp:24'h0F0F0F + 24'h3FFFFF + 24'h000101 + 24'h7A5A5A, exp_cnt:4};

    do_reset();

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++) pkt[i] = vecs[v].ops[i];
      run_packet(vecs[v].n, vecs[v].gaps, vecs[v].hold, vecs[v].exp, vecs[v].exp_cnt,
                 $sformatf("vec%0d", v));
    end

    // Reset mid-packet discards the partial sum.
    in_valid = 1'b1; in_last = 1'b0; in_data = 24'd100; tick();
    in_data = 24'd200; tick();
    in_valid = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst no_valid", {31'd0, out_valid}, 32'd0);
    end
    pkt[0] = 24'd1;
    run_packet(1, 1'b0, 0, 24'd1, 1, "midrst");

    // Reset while a result is pending drops it.
    pkt[0] = 24'd77; pkt[1] = 24'd5;
    in_valid = 1'b1; in_data = 24'd77; in_last = 1'b0; tick();
    in_data = 24'd5; in_last = 1'b1; tick();
    in_valid = 1'b0; tick();
    chk("outrst pending", {31'd0, out_valid}, 32'd1);
    do_reset();
    tick();
    chk("outrst dropped", {31'd0, out_valid}, 32'd0);
    pkt[0] = 24'h000042;
    run_packet(1, 1'b0, 0, 24'h000042, 1, "outrst");

    // Randomized packets against the packet-sum model.
    for (int r = 0; r < 25; r++) begin
      int n;
      logic [23:0] sum;
      n   = int'($urandom_range(1, 12));
      sum = 24'd0;
      for (int i = 0; i < n; i++) begin
        pkt[i] = 24'($urandom);
        sum    = sum + pkt[i];
      end
      run_packet(n, 1'b1, int'($urandom_range(0, 3)), sum, n, $sformatf("rnd%0d", r));
    end

    // Long packet: sum 300, counter saturates.
    for (int i = 0; i < 300; i++) pkt[i] = 24'd1;
    run_packet(300, 1'b0, 0, 24'h00012C, 255, "long");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
